// File: rtl/rv_divide_multi.sv
`default_nettype none
// ============================================================================
//  Module      : rv_divide_multi
//  Description : Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with
//                parameterised width and radix (G_UNROLL steps per clock).
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_divide_multi #(
    parameter int G_WIDTH  = 32,
    parameter int G_UNROLL = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               x_stall_i,
    input  logic               x_kill_i,
    output logic               x_stall_req_o,
    output logic               x_valid_o,
    input  logic               d_valid_i,
    input  logic               d_is_divide_i,
    input  logic [2:0]         d_fun_i,
    input  logic [G_WIDTH-1:0] d_rs1_i,
    input  logic [G_WIDTH-1:0] d_rs2_i,
    output logic [G_WIDTH-1:0] x_rd_o
);

    localparam int c_N_ITER = G_WIDTH / G_UNROLL;
    localparam int c_CNT_W  = (c_N_ITER > 1) ? $clog2(c_N_ITER) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N_ITER - 1);
    localparam logic [G_WIDTH-1:0] c_MIN = {1'b1, {(G_WIDTH-1){1'b0}}};

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_PREP = 3'd1;
    localparam logic [2:0] c_S_ITER = 3'd2;
    localparam logic [2:0] c_S_FIX  = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               w_start;

    logic [G_WIDTH-1:0] r_rs1;
    logic [G_WIDTH-1:0] r_rs2;
    logic               r_is_rem;
    logic               r_sgn;
    logic               r_n_sign;
    logic               r_d_sign;
    logic [G_WIDTH-1:0] r_n;
    logic [G_WIDTH-1:0] r_d;
    logic [G_WIDTH-1:0] r_q;
    logic [G_WIDTH-1:0] r_r;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_special;
    logic [G_WIDTH-1:0] r_spec_val;
    logic [G_WIDTH-1:0] r_rd;

    logic [G_WIDTH-1:0] w_n_abs;
    logic [G_WIDTH-1:0] w_d_abs;
    logic               w_div0;
    logic               w_ovf;
    logic [G_WIDTH-1:0] w_spec_val;
    logic [G_WIDTH-1:0] w_result;

    logic [G_WIDTH:0]   w_rp;
    logic               w_ge;
    logic [G_WIDTH-1:0] w_r_nx;
    logic [G_WIDTH-1:0] w_n_nx;
    logic [G_WIDTH-1:0] w_q_nx;

    // funct3[2] is implied by d_is_divide_i
    logic w_unused_fun2;
    assign w_unused_fun2 = d_fun_i[2];

    assign w_start = d_valid_i & d_is_divide_i & ~x_stall_i & ~x_kill_i;

    assign x_valid_o     = (r_state == c_S_DONE);
    assign x_stall_req_o = ((r_state == c_S_IDLE) & w_start) |
                           (r_state == c_S_PREP) | (r_state == c_S_ITER) |
                           (r_state == c_S_FIX);
    assign x_rd_o        = r_rd;

    // Operand preparation works only on the captured copies
    assign w_n_abs    = r_n_sign ? -r_rs1 : r_rs1;
    assign w_d_abs    = r_d_sign ? -r_rs2 : r_rs2;
    assign w_div0     = (r_rs2 == '0);
    assign w_ovf      = r_sgn & (r_rs1 == c_MIN) & (r_rs2 == '1);
    assign w_spec_val = r_is_rem ? (w_div0 ? r_rs1 : '0)
                                 : (w_div0 ? '1    : c_MIN);
    assign w_result   = r_special ? r_spec_val :
                        r_is_rem  ? (r_n_sign ? -r_r : r_r) :
                                    ((r_n_sign ^ r_d_sign) ? -r_q : r_q);

    // G_UNROLL chained restoring steps; r' < 2d so the low bits of r'-d are exact
    always_comb begin
        w_rp   = '0;
        w_ge   = 1'b0;
        w_r_nx = r_r;
        w_n_nx = r_n;
        w_q_nx = r_q;
        for (int i = 0; i < G_UNROLL; i++) begin
            w_rp   = {w_r_nx, w_n_nx[G_WIDTH-1]};
            w_ge   = (w_rp >= {1'b0, r_d});
            w_r_nx = w_ge ? (w_rp[G_WIDTH-1:0] - r_d) : w_rp[G_WIDTH-1:0];
            w_n_nx = {w_n_nx[G_WIDTH-2:0], 1'b0};
            w_q_nx = {w_q_nx[G_WIDTH-2:0], w_ge};
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (w_start) w_next_state = c_S_PREP;
            c_S_PREP: w_next_state = (w_div0 | w_ovf) ? c_S_FIX : c_S_ITER;
            c_S_ITER: if (r_cnt == c_CNT_LAST) w_next_state = c_S_FIX;
            c_S_FIX:  w_next_state = c_S_DONE;
            c_S_DONE: if (!x_stall_i) w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
        // Kill outranks everything, including the stall hold in DONE
        if (x_kill_i && (r_state != c_S_IDLE)) w_next_state = c_S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= c_S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_is_rem   <= 1'b0;
            r_sgn      <= 1'b0;
            r_n_sign   <= 1'b0;
            r_d_sign   <= 1'b0;
            r_n        <= '0;
            r_d        <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_special  <= 1'b0;
            r_spec_val <= '0;
            r_rd       <= '0;
        end else if (!x_kill_i) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_start) begin
                        r_rs1    <= d_rs1_i;
                        r_rs2    <= d_rs2_i;
                        r_is_rem <= d_fun_i[1];
                        r_sgn    <= ~d_fun_i[0];
                        r_n_sign <= ~d_fun_i[0] & d_rs1_i[G_WIDTH-1];
                        r_d_sign <= ~d_fun_i[0] & d_rs2_i[G_WIDTH-1];
                    end
                end
                c_S_PREP: begin
                    r_n        <= w_n_abs;
                    r_d        <= w_d_abs;
                    r_q        <= '0;
                    r_r        <= '0;
                    r_cnt      <= '0;
                    r_special  <= w_div0 | w_ovf;
                    r_spec_val <= w_spec_val;
                end
                c_S_ITER: begin
                    r_n   <= w_n_nx;
                    r_r   <= w_r_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
                c_S_FIX: r_rd <= w_result;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_divide_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_divide_multi
//  Description : Directed self-checking bench for rv_divide_multi (radix 2 and
//                radix 16 instances driven in parallel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_divide_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        kill;
    logic        d_valid;
    logic        d_is_div;
    logic [2:0]  d_fun;
    logic [31:0] rs1;
    logic [31:0] rs2;

    logic        stall_req1, valid1;
    logic [31:0] rd1;
    logic        stall_req4, valid4;
    logic [31:0] rd4;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] c_DIV  = 3'b100;
    localparam logic [2:0] c_DIVU = 3'b101;
    localparam logic [2:0] c_REM  = 3'b110;
    localparam logic [2:0] c_REMU = 3'b111;

    always #5 clk = ~clk;

    rv_divide_multi #(.G_WIDTH(32), .G_UNROLL(1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .x_kill_i(kill),
        .x_stall_req_o(stall_req1), .x_valid_o(valid1),
        .d_valid_i(d_valid), .d_is_divide_i(d_is_div), .d_fun_i(d_fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd1)
    );

    rv_divide_multi #(.G_WIDTH(32), .G_UNROLL(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(stall), .x_kill_i(kill),
        .x_stall_req_o(stall_req4), .x_valid_o(valid4),
        .d_valid_i(d_valid), .d_is_divide_i(d_is_div), .d_fun_i(d_fun),
        .d_rs1_i(rs1), .d_rs2_i(rs2), .x_rd_o(rd4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one start, then count edges (start edge = 1) until DONE
    task automatic issue(input logic [2:0] fun, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        d_valid  = 1'b1;
        d_is_div = 1'b1;
        d_fun    = fun;
        rs1      = a;
        rs2      = b;
    endtask

    task automatic run_op(input string tag, input logic [2:0] fun, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int lat1, input int lat4);
        int n;
        int l4;
        issue(fun, a, b);
        #1 check({tag, " stall_req at start"}, {31'b0, stall_req1}, 32'd1);
        @(posedge clk);
        n  = 1;
        l4 = 0;
        #1;
        d_valid = 1'b0;
        rs1     = ~a;
        rs2     = ~b;
        if (valid4) l4 = n;
        while (!valid1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (valid4 && l4 == 0) l4 = n;
        end
        check({tag, " latency u1"}, n, lat1);
        check({tag, " result u1"}, rd1, exp);
        check({tag, " latency u4"}, l4, lat4);
        check({tag, " result u4"}, rd4, exp);
        check({tag, " stall_req in DONE"}, {31'b0, stall_req1}, 32'd0);
        @(posedge clk);
        #1 check({tag, " back to idle"}, {31'b0, valid1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic seen;
        rst_n = 1'b0; stall = 1'b0; kill = 1'b0;
        d_valid = 1'b0; d_is_div = 1'b0; d_fun = 3'b000; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        check("reset rd", rd1, 32'h0);
        check("reset valid", {31'b0, valid1}, 32'd0);
        check("reset stall_req", {31'b0, stall_req1}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned and signed normal cases
        run_op("DIVU 100/7", c_DIVU, 32'd100, 32'd7, 32'd14, 35, 11);
        run_op("REMU 100/7", c_REMU, 32'd100, 32'd7, 32'd2, 35, 11);
        run_op("DIV -7/2", c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 11);
        run_op("REM -7/2", c_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 11);
        run_op("REM 7/-2", c_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 35, 11);
        run_op("DIV MIN/2", c_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 35, 11);
        run_op("DIVU FFFFFFFF/1", c_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, 11);
        run_op("DIVU MIN/-1", c_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 35, 11);
        run_op("REMU MIN/-1", c_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 35, 11);

        // Early special results
        run_op("DIV 5/0", c_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 3, 3);
        run_op("REM 5/0", c_REM, 32'd5, 32'd0, 32'd5, 3, 3);
        run_op("DIVU 5/0", c_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 3, 3);
        run_op("DIV MIN/-1", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 3, 3);
        run_op("REM MIN/-1", c_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 3, 3);
        run_op("DIV -7/-2", c_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 35, 11);

        // Kill in ITER cycle 10
        issue(c_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        #1 d_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill stall_req", {31'b0, stall_req1}, 32'd0);
        check("kill valid", {31'b0, valid1}, 32'd0);
        check("kill rd kept", rd1, 32'd3);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (valid1) seen = 1'b1;
        end
        check("kill no valid later", {31'b0, seen}, 32'd0);
        check("kill rd still kept", rd1, 32'd3);
        run_op("DIVU 1000/3 after kill", c_DIVU, 32'd1000, 32'd3, 32'd333, 35, 11);

        // Stall hold in DONE
        issue(c_DIVU, 32'hFFFF_FFFF, 32'h10);
        @(posedge clk);
        #1 d_valid = 1'b0;
        n = 1;
        while (!valid1 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("stall latency", n, 35);
        stall = 1'b1;
        d_valid = 1'b1; d_fun = c_DIVU; rs1 = 32'd9; rs2 = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall hold valid", {31'b0, valid1}, 32'd1);
            check("stall hold rd", rd1, 32'h0FFF_FFFF);
            check("stall hold stall_req", {31'b0, stall_req1}, 32'd0);
        end
        @(negedge clk);
        stall = 1'b0;
        d_valid = 1'b0;
        @(posedge clk);
        #1 check("stall release valid", {31'b0, valid1}, 32'd0);
        @(posedge clk);
        #1 check("stall no new start", {31'b0, stall_req1}, 32'd0);
        check("stall rd after release", rd1, 32'h0FFF_FFFF);

        // Asynchronous reset mid-ITER
        issue(c_REMU, 32'd100, 32'd7);
        @(posedge clk);
        #1 d_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset rd u1", rd1, 32'h0);
        check("async reset rd u4", rd4, 32'h0);
        check("async reset valid u4", {31'b0, valid4}, 32'd0);
        check("async reset stall_req", {31'b0, stall_req1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("REMU FFFFFFFF/16 after reset", c_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 35, 11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
